prei_mode_buf: RTL

Ping-pong buffer between the pre-intra stage (mode decision plus CTU rate control) and the downstream intra/encode stage. It captures the per-CTU best-mode writes (128 entries × 6 bit) and the CTU QP into one of two banks. It hands the filled bank to the consumer, so pre-intra of CTU n+1 overlaps encoding of CTU n. The block owns the bank-state handshake on both sides and flags protocol errors.

---
 rtl/prei_mode_buf_if.sv | 35 +++
 rtl/prei_mode_buf.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prei_mode_buf_if.sv
// prei_mode_buf_if: producer/consumer bus of the pre-intra ping-pong mode buffer.
// master: pre-intra producer and intra consumer side (drives pulses, writes, reads).
// slave : the buffer itself (drives status, read data, QP and error flag).
interface prei_mode_buf_if;
    // producer side
    logic       wr_start_i;
    logic       wr_done_i;
    logic       md_we_i;
    logic [6:0] md_waddr_i;
    logic [5:0] md_wdata_i;
    logic [5:0] rc_qp_i;
    logic       wr_rdy_o;
    // consumer side
    logic       rd_valid_o;
    logic       rd_start_i;
    logic       rd_done_i;
    logic       rd_en_i;
    logic [6:0] rd_addr_i;
    logic [5:0] rd_data_o;
    logic [5:0] rd_qp_o;
    // status
    logic       err_o;

    modport master (
        output wr_start_i, wr_done_i, md_we_i, md_waddr_i, md_wdata_i, rc_qp_i,
        output rd_start_i, rd_done_i, rd_en_i, rd_addr_i,
        input  wr_rdy_o, rd_valid_o, rd_data_o, rd_qp_o, err_o
    );

    modport slave (
        input  wr_start_i, wr_done_i, md_we_i, md_waddr_i, md_wdata_i, rc_qp_i,
        input  rd_start_i, rd_done_i, rd_en_i, rd_addr_i,
        output wr_rdy_o, rd_valid_o, rd_data_o, rd_qp_o, err_o
    );
endinterface

// File: rtl/prei_mode_buf.sv
// prei_mode_buf: two-bank ping-pong buffer holding 128 x 6-bit best modes plus the
// CTU QP, letting pre-intra of CTU n+1 overlap encoding of CTU n.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   bus        prei_mode_buf_if.slave: producer write/claim/done, consumer
//              start/done/read, wr_rdy_o, rd_valid_o, rd_data_o, rd_qp_o, err_o
// Optional feature: define PREI_MODE_BUF_CHK_EN to count writes per bank and flag
// a wr_done_i whose CTU did not receive exactly 128 writes.
module prei_mode_buf (
    input  logic           clk,
    input  logic           rstn,
    prei_mode_buf_if.slave bus
);
    localparam int unsigned DEPTH = 128;
    localparam int unsigned DW    = 6;
    localparam int unsigned QW    = 6;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic          err_q, err_d;
    logic [QW-1:0] qp_q [2];
    logic [QW-1:0] rd_qp_q;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] mem [2*DEPTH];

    logic fill_any_c, fill_bank_c, read_any_c, read_bank_c;
    logic wr_rdy_c, rd_valid_c;
    logic wr_start_ok_c, wr_done_ok_c, rd_start_ok_c, rd_done_ok_c;
    logic we_ok_c, we_bank_c, rd_bank_c;
    logic chk_err_c;

    // Bank status decode and event acceptance
    always_comb begin
        fill_any_c    = (state_q[0] == FILLING) || (state_q[1] == FILLING);
        fill_bank_c   = (state_q[1] == FILLING);
        read_any_c    = (state_q[0] == READING) || (state_q[1] == READING);
        read_bank_c   = (state_q[1] == READING);
        wr_rdy_c      = (state_q[wr_sel_q] == EMPTY) && !fill_any_c;
        rd_valid_c    = (state_q[rd_sel_q] == FULL) && !read_any_c;
        wr_start_ok_c = bus.wr_start_i && wr_rdy_c;
        wr_done_ok_c  = bus.wr_done_i && fill_any_c;
        rd_start_ok_c = bus.rd_start_i && rd_valid_c;
        rd_done_ok_c  = bus.rd_done_i && read_any_c;
        // a write coinciding with an accepted claim lands in the newly claimed bank
        we_ok_c       = bus.md_we_i && (wr_start_ok_c || fill_any_c);
        we_bank_c     = wr_start_ok_c ? wr_sel_q : fill_bank_c;
        // with nothing READING the read falls on the bank the consumer is not pointing at
        rd_bank_c     = read_any_c ? read_bank_c : ~rd_sel_q;
    end

`ifdef PREI_MODE_BUF_CHK_EN
    localparam int unsigned CW = 8;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    // Per-bank write counter; saturates so an over-long CTU cannot wrap back to 128
    always_comb begin
        cnt_d[0] = cnt_q[0];
        cnt_d[1] = cnt_q[1];
        if (wr_start_ok_c) begin
            cnt_d[wr_sel_q] = '0;
        end
        if (we_ok_c && (cnt_d[we_bank_c] != '1)) begin
            cnt_d[we_bank_c] = cnt_d[we_bank_c] + CW'(1);
        end
        chk_err_c = wr_done_ok_c && (cnt_d[fill_bank_c] != CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end
`else
    always_comb begin
        chk_err_c = 1'b0;
    end
`endif

    // Bank state machines, pointers and sticky error: next state
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        err_d      = err_q;
        if (wr_start_ok_c) begin
            state_d[wr_sel_q] = FILLING;
            wr_sel_d          = ~wr_sel_q;
        end
        if (wr_done_ok_c) begin
            state_d[fill_bank_c] = FULL;
        end
        if (rd_start_ok_c) begin
            state_d[rd_sel_q] = READING;
            rd_sel_d          = ~rd_sel_q;
        end
        if (rd_done_ok_c) begin
            state_d[read_bank_c] = EMPTY;
        end
        if ((bus.wr_start_i && !wr_rdy_c) || (bus.wr_done_i && !fill_any_c) ||
            (bus.rd_start_i && !rd_valid_c) || (bus.rd_done_i && !read_any_c) ||
            (bus.md_we_i && !we_ok_c) || chk_err_c) begin
            err_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            err_q      <= err_d;
        end
    end

    // QP capture per bank and QP/mode read-out registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qp_q[0]   <= '0;
            qp_q[1]   <= '0;
            rd_qp_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_done_ok_c) begin
                qp_q[fill_bank_c] <= bus.rc_qp_i;
            end
            if (rd_start_ok_c) begin
                rd_qp_q <= qp_q[rd_sel_q];
            end
            if (bus.rd_en_i) begin
                rd_data_q <= mem[{rd_bank_c, bus.rd_addr_i}];
            end
        end
    end

    // Mode storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (we_ok_c) begin
            mem[{we_bank_c, bus.md_waddr_i}] <= bus.md_wdata_i;
        end
    end

    assign bus.wr_rdy_o   = wr_rdy_c;
    assign bus.rd_valid_o = rd_valid_c;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_qp_o    = rd_qp_q;
    assign bus.err_o      = err_q;
endmodule
